// File: rtl/i2c_master_seq.sv
// i2c_master_seq: multi-byte I2C master (START, addr+R/W, N bytes, STOP); define I2C_CLK_STRETCH_EN for slave clock stretching
module i2c_master_seq #(
  parameter int DIV_STD = 40,
  parameter int DIV_FAST = 10,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic [6:0]       cmd_addr,
  input  logic             cmd_rw,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_fast,
  input  logic [7:0]       tx_data,
  output logic             tx_req,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             nack_err,
  input  logic             scl_i,
  output logic             scl_oe,
  input  logic             sda_i,
  output logic             sda_oe
);
  typedef enum logic [3:0] {IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP} state_t;
  localparam int QW = $clog2(DIV_STD > DIV_FAST ? DIV_STD : DIV_FAST) + 1;
  state_t state;
  logic [QW-1:0] qcnt, qmax;
  logic [1:0] q;
  logic [2:0] bitn;
  logic [7:0] sh;
  logic [LEN_W-1:0] rem;
  logic rw, fast, err, ackb, freeze, tick, smp, scl_drv, sda_drv;
`ifdef I2C_CLK_STRETCH_EN
  assign freeze = q == 2'd2 && !scl_oe && !scl_i;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign freeze = 1'b0;
`endif
  assign qmax = fast ? QW'(DIV_FAST - 1) : QW'(DIV_STD - 1);
  assign tick = !freeze && qcnt == qmax;
  assign smp = q == 2'd3 && qcnt == '0;
  assign scl_drv = state != IDLE && state != START && !q[1];
  assign sda_drv = (state == START && q[1]) ||
                   ((state == ADDR || state == WRITE) && !sh[7]) ||
                   (state == READ_ACK && rem != '0) ||
                   (state == STOP && q != 2'd3);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      qcnt <= '0;
      q <= '0;
      bitn <= '0;
      sh <= '0;
      rem <= '0;
      rw <= 1'b0;
      fast <= 1'b0;
      err <= 1'b0;
      ackb <= 1'b0;
      scl_oe <= 1'b0;
      sda_oe <= 1'b0;
      tx_req <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      nack_err <= 1'b0;
    end else begin
      scl_oe <= scl_drv;
      sda_oe <= sda_drv;
      done <= 1'b0;
      tx_req <= 1'b0;
      rx_valid <= 1'b0;
      if (state == IDLE) begin
        qcnt <= '0;
        q <= '0;
        if (cmd_start) begin
          state <= START;
          sh <= {cmd_addr, cmd_rw};
          rw <= cmd_rw;
          rem <= cmd_len;
          fast <= cmd_fast;
          err <= 1'b0;
          busy <= 1'b1;
          nack_err <= 1'b0;
        end
      end else begin
        if (smp) begin
          ackb <= sda_i;
          if (state == READ) sh <= {sh[6:0], sda_i};
        end
        if (!freeze) qcnt <= tick ? '0 : qcnt + 1'b1;
        if (tick) begin
          q <= q + 2'd1;
          if (q == 2'd3) begin
            bitn <= bitn - 3'd1;
            case (state)
              START: begin
                state <= ADDR;
                bitn <= 3'd7;
              end
              ADDR: begin
                sh <= {sh[6:0], 1'b0};
                if (bitn == 3'd0) state <= ADDR_ACK;
              end
              ADDR_ACK: begin
                bitn <= 3'd7;
                if (ackb || rem == '0) begin
                  state <= STOP;
                  err <= ackb;
                end else if (rw) begin
                  state <= READ;
                end else begin
                  state <= WRITE;
                  sh <= tx_data;
                  tx_req <= 1'b1;
                end
              end
              WRITE: begin
                sh <= {sh[6:0], 1'b0};
                if (bitn == 3'd0) begin
                  state <= WRITE_ACK;
                  rem <= rem - 1'b1;
                end
              end
              WRITE_ACK: begin
                bitn <= 3'd7;
                if (ackb) begin
                  state <= STOP;
                  err <= 1'b1;
                end else if (rem != '0) begin
                  state <= WRITE;
                  sh <= tx_data;
                  tx_req <= 1'b1;
                end else begin
                  state <= STOP;
                end
              end
              READ: begin
                if (bitn == 3'd0) begin
                  state <= READ_ACK;
                  rx_data <= sh;
                  rx_valid <= 1'b1;
                  rem <= rem - 1'b1;
                end
              end
              READ_ACK: begin
                state <= rem != '0 ? READ : STOP;
                bitn <= 3'd7;
              end
              STOP: begin
                state <= IDLE;
                busy <= 1'b0;
                done <= 1'b1;
                nack_err <= err;
              end
              default: state <= IDLE;
            endcase
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_master_seq.sv
// tb_i2c_master_seq: vector table of transactions against a bit-scripted slave, plus reset and stretch sequences
module tb_i2c_master_seq;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic cmd_start = 0, cmd_rw = 0, cmd_fast = 0;
  logic [6:0] cmd_addr = 0;
  logic [3:0] cmd_len = 0;
  logic [7:0] tx_data, rx_data, tx_base = 0;
  logic tx_req, rx_valid, busy, done, nack_err, scl_oe, sda_oe;
  logic hold = 0, sda_slave = 0, stretch = 0, scl_line, sda_line;
  assign scl_line = !(scl_oe || hold);
  assign sda_line = !(sda_oe || sda_slave);
  int checks = 0, failures = 0;
  int krise = 0, kfall = 0, fb = 0, txn = 0, txn0 = 0, rxn = 0;
  logic cap [0:1023];
  logic drv [0:255];
  logic [7:0] rxq [0:63];
  assign tx_data = tx_base + 8'(txn - txn0);

  i2c_master_seq dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_addr(cmd_addr), .cmd_rw(cmd_rw),
    .cmd_len(cmd_len), .cmd_fast(cmd_fast), .tx_data(tx_data), .tx_req(tx_req),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done), .nack_err(nack_err),
    .scl_i(scl_line), .scl_oe(scl_oe), .sda_i(sda_line), .sda_oe(sda_oe)
  );

  always @(posedge scl_line) begin
    if (krise < 1024) cap[krise] = sda_line;
    krise++;
  end

  always @(negedge scl_line) begin
    sda_slave = (kfall - fb) < 256 ? drv[kfall - fb] : 1'b0;
    kfall++;
    if (stretch && kfall - fb == 4) begin
      hold = 1;
      @(negedge scl_oe);
      repeat (100) @(posedge clk);
      #1 hold = 0;
    end
  end

  always @(negedge clk) begin
    if (tx_req === 1'b1) txn++;
    if (rx_valid === 1'b1) begin
      if (rxn < 64) rxq[rxn] = rx_data;
      rxn++;
    end
  end

  typedef struct {
    logic [6:0] addr; logic rw; logic [3:0] len; logic fast; logic [7:0] tx; logic [23:0] rd;
    int nack_at; int lat; logic nack; int ntx; int nrx; int poke;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] getbyte(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = cap[base + i];
    return b;
  endfunction

  task automatic run(input int v, input int extra);
    int n, rb, rx0;
    logic [7:0] rbyte;
    for (int k = 0; k < 256; k++) drv[k] = 0;
    drv[8] = vt[v].nack_at != 0;
    for (int j = 0; j < vt[v].len; j++) begin
      rbyte = 8'(vt[v].rd >> (8 * (vt[v].len - 1 - j)));
      if (vt[v].rw) for (int i = 0; i < 8; i++) drv[9*(j+1) + i] = !rbyte[7-i];
      else drv[9*(j+1) + 8] = vt[v].nack_at != j + 1;
    end
    fb = kfall; rb = krise; rx0 = rxn; txn0 = txn; tx_base = vt[v].tx;
    @(negedge clk);
    cmd_addr = vt[v].addr; cmd_rw = vt[v].rw; cmd_len = vt[v].len; cmd_fast = vt[v].fast;
    cmd_start = 1;
    @(posedge clk);
    @(negedge clk);
    cmd_start = 0;
    n = 0;
    while (n < 10000) begin
      @(posedge clk);
      #1 n++;
      if (done) break;
      if (n == 5) chk($sformatf("busy_mid v%0d", v), busy, 1);
      if (vt[v].poke != 0 && n == 200) begin
        cmd_start = 1;
        cmd_addr = 7'h11;
      end else cmd_start = 0;
    end
    cmd_start = 0;
    checks++;
    if (n < vt[v].lat + extra - 2 || n > vt[v].lat + extra + 2) begin
      failures++;
      $display("FAIL latency v%0d actual=%0d required=%0d+/-2", v, n, vt[v].lat + extra);
    end
    chk($sformatf("done_busy v%0d", v), busy, 0);
    chk($sformatf("nack_err v%0d", v), nack_err, vt[v].nack);
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("idle_busy v%0d", v), busy, 0);
    chk($sformatf("nack_hold v%0d", v), nack_err, vt[v].nack);
    chk($sformatf("addr_byte v%0d", v), getbyte(rb), {vt[v].addr, vt[v].rw});
    chk($sformatf("tx_req_count v%0d", v), txn - txn0, vt[v].ntx);
    chk($sformatf("rx_valid_count v%0d", v), rxn - rx0, vt[v].nrx);
    for (int j = 1; j <= vt[v].ntx; j++)
      chk($sformatf("wr_byte v%0d b%0d", v, j), getbyte(rb + 9*j), vt[v].tx + 8'(j - 1));
    for (int j = 0; j < vt[v].nrx; j++) begin
      chk($sformatf("rd_byte v%0d b%0d", v, j), rxq[rx0 + j], 8'(vt[v].rd >> (8 * (vt[v].len - 1 - j))));
      chk($sformatf("master_ack v%0d b%0d", v, j), cap[rb + 9*(j+1) + 8], j == vt[v].len - 1);
    end
  endtask

  initial begin
    int n;
    vt[0] = '{7'h50, 1'b0, 4'd1, 1'b1, 8'hA5, 24'h0,      99, 800,  1'b0, 1, 0, 0};
    vt[1] = '{7'h21, 1'b0, 4'd2, 1'b0, 8'h33, 24'h0,      0,  1760, 1'b1, 0, 0, 0};
    vt[2] = '{7'h68, 1'b1, 4'd3, 1'b1, 8'h00, 24'h112233, 99, 1520, 1'b0, 0, 3, 0};
    vt[3] = '{7'h3C, 1'b0, 4'd0, 1'b1, 8'h00, 24'h0,      99, 440,  1'b0, 0, 0, 1};
    vt[4] = '{7'h0F, 1'b0, 4'd2, 1'b1, 8'h5A, 24'h0,      1,  800,  1'b1, 1, 0, 0};
    vt[5] = '{7'h7E, 1'b1, 4'd1, 1'b0, 8'h00, 24'hC3,     99, 3200, 1'b0, 0, 1, 0};
    #12;
    chk("reset_outputs", {scl_oe, sda_oe, busy, done, nack_err, tx_req, rx_valid, rx_data}, 0);
    @(negedge clk);
    rst = 0;
    repeat (3) @(posedge clk);
    #1 chk("idle_lines", {scl_oe, sda_oe, busy}, 0);
    for (int v = 0; v < 6; v++) run(v, 0);
    // abort a write mid-byte and make sure the bus is released at once
    for (int k = 0; k < 256; k++) drv[k] = 0;
    drv[8] = 1;
    fb = kfall;
    @(negedge clk);
    cmd_addr = 7'h50; cmd_rw = 0; cmd_len = 1; cmd_fast = 1; cmd_start = 1;
    @(negedge clk);
    cmd_start = 0;
    n = 0;
    while (n < 2000) begin
      @(posedge clk);
      #1 n++;
      if (tx_req) break;
    end
    chk("tx_req_before_reset", tx_req, 1);
    repeat (175) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    repeat (2) @(posedge clk);
    run(3, 0);
    run(0, 0);
`ifdef I2C_CLK_STRETCH_EN
    stretch = 1;
    run(3, 100);
    stretch = 0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
